// File: rtl/interconnect_ctrl_fsm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interconnect_ctrl_fsm_if : control/status bundle of the QoS interconnect   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface interconnect_ctrl_fsm_if #(
  parameter int LEN4  = 4,
  parameter int LEN16 = 16,
  parameter int CNTW  = 16
);
  logic                init;
  logic [4:0]          fifo_empty;
  logic [4:0]          fifo_error;
  logic [2*LEN4-1:0]   UmbralMF_in;
  logic [2*LEN16-1:0]  UmbralV0_in;
  logic [2*LEN16-1:0]  UmbralV1_in;
  logic [2*LEN4-1:0]   UmbralD0_in;
  logic [2*LEN4-1:0]   UmbralD1_in;
  logic [2*LEN4-1:0]   UmbralMF_out;
  logic [2*LEN16-1:0]  UmbralV0_out;
  logic [2*LEN16-1:0]  UmbralV1_out;
  logic [2*LEN4-1:0]   UmbralD0_out;
  logic [2*LEN4-1:0]   UmbralD1_out;
  logic [4:0]          state;
  logic                idle_out;
  logic                active_out;
  logic                error_out;
  logic                flow_en;
  logic                cfg_invalid;
  logic [4:0]          error_src;
  logic [CNTW-1:0]     active_cycles;

  modport master (
    output init, fifo_empty, fifo_error,
    output UmbralMF_in, UmbralV0_in, UmbralV1_in, UmbralD0_in, UmbralD1_in,
    input  UmbralMF_out, UmbralV0_out, UmbralV1_out, UmbralD0_out, UmbralD1_out,
    input  state, idle_out, active_out, error_out, flow_en, cfg_invalid,
    input  error_src, active_cycles
  );

  modport slave (
    input  init, fifo_empty, fifo_error,
    input  UmbralMF_in, UmbralV0_in, UmbralV1_in, UmbralD0_in, UmbralD1_in,
    output UmbralMF_out, UmbralV0_out, UmbralV1_out, UmbralD0_out, UmbralD1_out,
    output state, idle_out, active_out, error_out, flow_en, cfg_invalid,
    output error_src, active_cycles
  );
endinterface
`default_nettype wire

// File: rtl/interconnect_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interconnect_ctrl_fsm : reset/config/idle/active/error sequencer + Umbral  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module interconnect_ctrl_fsm #(
  parameter int LEN4  = 4,
  parameter int LEN16 = 16,
  parameter int CNTW  = 16
) (
  input  wire logic               clk,
  input  wire logic               reset_L,
  interconnect_ctrl_fsm_if.slave  bus
);

  localparam logic [4:0] c_RESET  = 5'b00001;
  localparam logic [4:0] c_INIT   = 5'b00010;
  localparam logic [4:0] c_IDLE   = 5'b00100;
  localparam logic [4:0] c_ACTIVE = 5'b01000;
  localparam logic [4:0] c_ERROR  = 5'b10000;
  localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [4:0]          r_state;
  logic [4:0]          w_next;
  logic [2*LEN4-1:0]   r_umf;
  logic [2*LEN16-1:0]  r_uv0;
  logic [2*LEN16-1:0]  r_uv1;
  logic [2*LEN4-1:0]   r_ud0;
  logic [2*LEN4-1:0]   r_ud1;
  logic                r_cfg_invalid;
  logic [4:0]          r_error_src;
  logic [CNTW-1:0]     r_active_cycles;

  logic                w_err_any;
  logic                w_all_empty;
  logic                w_cfg_bad;

  // A threshold pair is {HIGH,LOW}; it is unusable when LOW is not below HIGH.
  function automatic logic bad4(input logic [2*LEN4-1:0] u);
    return u[LEN4-1:0] >= u[2*LEN4-1:LEN4];
  endfunction

  function automatic logic bad16(input logic [2*LEN16-1:0] u);
    return u[LEN16-1:0] >= u[2*LEN16-1:LEN16];
  endfunction

  assign w_err_any   = |bus.fifo_error;
  assign w_all_empty = &bus.fifo_empty;
  assign w_cfg_bad   = bad4(bus.UmbralMF_in)  | bad16(bus.UmbralV0_in) |
                       bad16(bus.UmbralV1_in) | bad4(bus.UmbralD0_in)  |
                       bad4(bus.UmbralD1_in);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= c_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_RESET: w_next = c_INIT;
      c_INIT: begin
        if (w_err_any)                    w_next = c_ERROR;
        else if (!bus.init && !w_cfg_bad) w_next = c_IDLE;
      end
      c_IDLE: begin
        if (w_err_any)         w_next = c_ERROR;
        else if (bus.init)     w_next = c_INIT;
        else if (!w_all_empty) w_next = c_ACTIVE;
      end
      c_ACTIVE: begin
        if (w_err_any)        w_next = c_ERROR;
        else if (bus.init)    w_next = c_INIT;
        else if (w_all_empty) w_next = c_IDLE;
      end
      c_ERROR: w_next = c_ERROR;
      default: w_next = c_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_umf           <= '0;
      r_uv0           <= '0;
      r_uv1           <= '0;
      r_ud0           <= '0;
      r_ud1           <= '0;
      r_cfg_invalid   <= 1'b0;
      r_error_src     <= '0;
      r_active_cycles <= '0;
    end else begin
      if (r_state == c_INIT) begin
        r_umf <= bus.UmbralMF_in;
        r_uv0 <= bus.UmbralV0_in;
        r_uv1 <= bus.UmbralV1_in;
        r_ud0 <= bus.UmbralD0_in;
        r_ud1 <= bus.UmbralD1_in;
      end
      // Flag only lives while the FSM is held in INIT by a bad capture.
      r_cfg_invalid <= (r_state == c_INIT) && (w_next == c_INIT) && w_cfg_bad;
      if ((w_next == c_ERROR) && (r_state != c_ERROR)) begin
        r_error_src <= bus.fifo_error;
      end
      if (r_state == c_INIT) begin
        r_active_cycles <= '0;
      end else if ((r_state == c_ACTIVE) && (r_active_cycles != '1)) begin
        r_active_cycles <= r_active_cycles + c_CNT_ONE;
      end
    end
  end

  always_comb begin
    bus.idle_out   = 1'b0;
    bus.active_out = 1'b0;
    bus.error_out  = 1'b0;
    bus.flow_en    = 1'b0;
    case (r_state)
      c_IDLE: begin
        bus.idle_out = 1'b1;
        bus.flow_en  = 1'b1;
      end
      c_ACTIVE: begin
        bus.active_out = 1'b1;
        bus.flow_en    = 1'b1;
      end
      c_ERROR: bus.error_out = 1'b1;
      default: ;
    endcase
  end

  assign bus.state         = r_state;
  assign bus.UmbralMF_out  = r_umf;
  assign bus.UmbralV0_out  = r_uv0;
  assign bus.UmbralV1_out  = r_uv1;
  assign bus.UmbralD0_out  = r_ud0;
  assign bus.UmbralD1_out  = r_ud1;
  assign bus.cfg_invalid   = r_cfg_invalid;
  assign bus.error_src     = r_error_src;
  assign bus.active_cycles = r_active_cycles;

endmodule
`default_nettype wire

// File: tb/tb_interconnect_ctrl_fsm.sv
`default_nettype none
// Randomized + directed bench for interconnect_ctrl_fsm against a rule-level model.
module tb_interconnect_ctrl_fsm;
  localparam int LEN4  = 4;
  localparam int LEN16 = 16;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;
  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

  logic clk;
  logic reset_L;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 0;

  interconnect_ctrl_fsm_if #(.LEN4(LEN4), .LEN16(LEN16), .CNTW(CNTW)) bus ();

  interconnect_ctrl_fsm #(.LEN4(LEN4), .LEN16(LEN16), .CNTW(CNTW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model state
  int          m_state = S_RESET;
  logic [7:0]  m_mf = '0, m_d0 = '0, m_d1 = '0;
  logic [31:0] m_v0 = '0, m_v1 = '0;
  bit          m_cfg_inv = 0;
  logic [4:0]  m_esrc = '0;
  int          m_cnt = 0;

  function automatic bit cfg_bad();
    return (bus.UmbralMF_in[3:0]   >= bus.UmbralMF_in[7:4])   ||
           (bus.UmbralV0_in[15:0]  >= bus.UmbralV0_in[31:16]) ||
           (bus.UmbralV1_in[15:0]  >= bus.UmbralV1_in[31:16]) ||
           (bus.UmbralD0_in[3:0]   >= bus.UmbralD0_in[7:4])   ||
           (bus.UmbralD1_in[3:0]   >= bus.UmbralD1_in[7:4]);
  endfunction

  always @(posedge clk or negedge reset_L) begin
    int nxt;
    bit bad;
    if (!reset_L) begin
      m_state = S_RESET; m_mf = '0; m_v0 = '0; m_v1 = '0; m_d0 = '0; m_d1 = '0;
      m_cfg_inv = 0; m_esrc = '0; m_cnt = 0;
    end else begin
      bad = cfg_bad();
      if (m_state == S_RESET)       nxt = S_INIT;
      else if (m_state == S_ERROR)  nxt = S_ERROR;
      else if (bus.fifo_error != 0) nxt = S_ERROR;
      else if (m_state == S_INIT)   nxt = (!bus.init && !bad) ? S_IDLE : S_INIT;
      else if (bus.init)            nxt = S_INIT;
      else                          nxt = (bus.fifo_empty == 5'h1f) ? S_IDLE : S_ACTIVE;
      if (m_state == S_INIT) begin
        m_mf = bus.UmbralMF_in; m_v0 = bus.UmbralV0_in; m_v1 = bus.UmbralV1_in;
        m_d0 = bus.UmbralD0_in; m_d1 = bus.UmbralD1_in;
        m_cnt = 0;
      end else if (m_state == S_ACTIVE && m_cnt < CMAX) begin
        m_cnt = m_cnt + 1;
      end
      if (nxt == S_ERROR && m_state != S_ERROR) m_esrc = bus.fifo_error;
      m_cfg_inv = (m_state == S_INIT) && (nxt == S_INIT) && bad;
      m_state = nxt;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("state",   bus.state, 64'(5'b1 << m_state));
    chk("umf",     bus.UmbralMF_out, m_mf);
    chk("uv0",     bus.UmbralV0_out, m_v0);
    chk("uv1",     bus.UmbralV1_out, m_v1);
    chk("ud0",     bus.UmbralD0_out, m_d0);
    chk("ud1",     bus.UmbralD1_out, m_d1);
    chk("idle",    bus.idle_out,   m_state == S_IDLE);
    chk("active",  bus.active_out, m_state == S_ACTIVE);
    chk("error",   bus.error_out,  m_state == S_ERROR);
    chk("flow_en", bus.flow_en,    m_state == S_IDLE || m_state == S_ACTIVE);
    chk("cfg_inv", bus.cfg_invalid, m_cfg_inv);
    chk("esrc",    bus.error_src, m_esrc);
    chk("cycles",  bus.active_cycles, m_cnt);
  endtask

  always @(negedge clk) if (cmp_en) compare_all();

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic gen4(output logic [7:0] v);
    logic [3:0] hi, lo;
    hi = 4'($urandom_range(0, 15));
    if ($urandom % 5 == 0 || hi == 0) lo = 4'($urandom_range(0, 15));
    else lo = 4'($urandom_range(0, int'(hi) - 1));
    v = {hi, lo};
  endtask

  task automatic gen16(output logic [31:0] v);
    logic [15:0] hi, lo;
    hi = 16'($urandom_range(0, 65535));
    if ($urandom % 8 == 0 || hi == 0) lo = 16'($urandom_range(0, 65535));
    else lo = 16'($urandom_range(0, int'(hi) - 1));
    v = {hi, lo};
  endtask

  initial begin
    reset_L = 0;
    bus.init = 0; bus.fifo_empty = 5'h1f; bus.fifo_error = 0;
    bus.UmbralMF_in = 8'h62; bus.UmbralV0_in = {16'd12, 16'd3};
    bus.UmbralV1_in = {16'd20, 16'd5}; bus.UmbralD0_in = 8'h52; bus.UmbralD1_in = 8'h41;
    tick(2);
    cmp_en = 1;
    chk("pin_reset_state", bus.state, 5'b00001);
    chk("pin_reset_flow", bus.flow_en, 0);

    // Reset release, init held 3 cycles, then release -> IDLE
    reset_L = 1; bus.init = 1;
    tick();
    chk("pin_t1_init", bus.state, 5'b00010);
    tick(2);
    bus.init = 0;
    tick();
    chk("pin_t1_idle", bus.state, 5'b00100);
    chk("pin_t1_mf", bus.UmbralMF_out, 8'h62);
    chk("pin_t1_v0", bus.UmbralV0_out, {16'd12, 16'd3});
    chk("pin_t1_cfg", bus.cfg_invalid, 0);
    chk("pin_t1_flow", bus.flow_en, 1);

    // Invalid D0 keeps INIT until corrected
    bus.init = 1; bus.UmbralD0_in = 8'h25;
    tick();
    bus.init = 0;
    tick();
    chk("pin_t2_stay", bus.state, 5'b00010);
    chk("pin_t2_cfg", bus.cfg_invalid, 1);
    bus.UmbralD0_in = 8'h52;
    tick();
    chk("pin_t2_idle", bus.state, 5'b00100);

    // Four active cycles
    bus.fifo_empty = 5'b11110;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pin_t3_active", bus.active_out, 1);
    end
    bus.fifo_empty = 5'h1f;
    tick();
    chk("pin_t3_back_idle", bus.state, 5'b00100);
    chk("pin_t3_cycles", bus.active_cycles, 4);

    // Thresholds frozen outside INIT
    bus.UmbralV1_in = {16'd40, 16'd7};
    tick();
    chk("pin_t5_frozen", bus.UmbralV1_out, {16'd20, 16'd5});
    bus.init = 1;
    tick();
    chk("pin_t5_in_init", bus.UmbralV1_out, {16'd20, 16'd5});
    bus.init = 0;
    tick();
    chk("pin_t5_captured", bus.UmbralV1_out, {16'd40, 16'd7});

    // Error beats init, then sticky
    bus.fifo_empty = 5'b11110;
    tick(2);
    bus.fifo_error = 5'b00100; bus.init = 1;
    tick();
    chk("pin_t4_state", bus.state, 5'b10000);
    chk("pin_t4_src", bus.error_src, 5'b00100);
    chk("pin_t4_flow", bus.flow_en, 0);
    bus.fifo_error = 0;
    tick(3);
    chk("pin_t4_sticky", bus.state, 5'b10000);
    #2 reset_L = 0;
    #1 chk("pin_t4_async", bus.state, 5'b00001);
    compare_all();

    // Counter saturation, then async reset mid-ACTIVE
    tick();
    reset_L = 1; bus.init = 1;
    tick();
    bus.init = 0;
    tick();
    bus.fifo_empty = 5'b01111;
    tick(20);
    chk("pin_t6_sat", bus.active_cycles, 15);
    #3 reset_L = 0;
    #1 chk("pin_t6_rst_cnt", bus.active_cycles, 0);
    chk("pin_t6_rst_mf", bus.UmbralMF_out, 0);
    compare_all();
    tick();
    reset_L = 1;

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] a, d0, d1;
      logic [31:0] v0, v1;
      reset_L = ($urandom % 300 != 0);
      bus.init = ($urandom % 10 == 0);
      bus.fifo_empty = ($urandom % 3 == 0) ? 5'h1f : 5'($urandom);
      bus.fifo_error = ($urandom % 120 == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      gen4(a); gen4(d0); gen4(d1); gen16(v0); gen16(v1);
      bus.UmbralMF_in = a; bus.UmbralD0_in = d0; bus.UmbralD1_in = d1;
      bus.UmbralV0_in = v0; bus.UmbralV1_in = v1;
      tick();
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
